// File: rtl/sevseg2hex_capture.sv
// rtl/sevseg2hex_capture.sv - seven-segment bus snooper decoding settled glyphs back to hex digits
module sevseg2hex_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            ca,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  invalid_pat,
    output logic                  multi_an
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [DIGITS-1:0] an_q, an_p, seen, seen_hit, sel;
    logic [6:0]        ca_q, ca_p;
    logic              smp_vld;
    logic [3:0]        zero_cnt;
    logic              onehot, multi, same, capture;
    logic [4:0]        dec;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    // The all-zero reset sample would look like MULTI; smp_vld makes it read as BLANK instead.
    always_comb begin
        zero_cnt = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) zero_cnt = zero_cnt + 4'd1;
        end
        onehot   = smp_vld && (zero_cnt == 4'd1);
        multi    = smp_vld && (zero_cnt >= 4'd2);
        same     = (an_q == an_p) && (ca_q == ca_p);
        sel      = ~an_q;
        seen_hit = seen | sel;
        dec      = decode(ca_q);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!onehot) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end else if (same && state != IDLE) begin
            if (cnt < STABLE) cnt_n = cnt + 8'd1;
            if (state == SETTLE && cnt_n == STABLE) begin
                capture = 1'b1;
                state_n = HELD;
            end
        end else begin
            state_n = SETTLE;
            cnt_n   = 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            an_q        <= '0;
            ca_q        <= '0;
            an_p        <= '0;
            ca_p        <= '0;
            smp_vld     <= 1'b0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            invalid_pat <= 1'b0;
            multi_an    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            an_q        <= an;
            ca_q        <= ca;
            an_p        <= an_q;
            ca_p        <= ca_q;
            smp_vld     <= 1'b1;
            frame_valid <= 1'b0;
            invalid_pat <= 1'b0;
            multi_an    <= multi;
            if (capture) begin
                if (dec[4]) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (sel[i]) begin
                            digits[4*i +: 4] <= dec[3:0];
                            digit_valid[i]   <= 1'b1;
                        end
                    end
                    if (&seen_hit) begin
                        frame_valid <= 1'b1;
                        seen        <= '0;
                    end else begin
                        seen        <= seen_hit;
                    end
                end else begin
                    invalid_pat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevseg2hex_capture.sv
// tb/tb_sevseg2hex_capture.sv - vector table, directed sequences and random traffic against a run-length model
module tb_sevseg2hex_capture;

    localparam int D = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [D-1:0]   an = '1;
    logic [6:0]     ca = '1;
    logic [4*D-1:0] digits;
    logic [D-1:0]   digit_valid;
    logic           frame_valid, invalid_pat, multi_an;

    sevseg2hex_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .ca(ca),
        .digits(digits), .digit_valid(digit_valid), .frame_valid(frame_valid),
        .invalid_pat(invalid_pat), .multi_an(multi_an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ca;
        logic [3:0] hex;
    } glyph_t;
    glyph_t glyphs[16];

    int n_vec = 0;
    int n_bad = 0;
    int fv_cnt = 0;
    int inv_cnt = 0;

    // Reference model: run length of identical one-hot samples, capture when it equals S.
    logic [3:0]   m_dig[D];
    logic [D-1:0] m_dv, m_seen;
    logic         m_fv, m_inv, m_multi;
    logic         m_pend, m_have_last;
    logic [D-1:0] m_pend_an, m_last_an;
    logic [6:0]   m_pend_ca, m_last_ca;
    int           m_run;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_dig[i] = 4'h0;
        m_dv = '0; m_seen = '0; m_fv = 0; m_inv = 0; m_multi = 0;
        m_pend = 0; m_have_last = 0; m_run = 0;
        m_pend_an = '0; m_pend_ca = '0; m_last_an = '0; m_last_ca = '0;
    endtask

    task automatic model_edge(input logic [D-1:0] a, input logic [6:0] c);
        int zeros, pos, found;
        m_fv = 0; m_inv = 0; m_multi = 0;
        if (m_pend) begin
            zeros = 0; pos = 0;
            for (int i = 0; i < D; i++) if (!m_pend_an[i]) begin zeros++; pos = i; end
            if (zeros >= 2) m_multi = 1;
            if (zeros == 1 && m_have_last && m_pend_an == m_last_an && m_pend_ca == m_last_ca)
                m_run++;
            else
                m_run = (zeros == 1) ? 1 : 0;
            if (zeros == 1 && m_run == S) begin
                found = -1;
                for (int g = 0; g < 16; g++) if (glyphs[g].ca == m_pend_ca) found = g;
                if (found >= 0) begin
                    m_dig[pos] = glyphs[found].hex;
                    m_dv[pos]  = 1'b1;
                    m_seen[pos] = 1'b1;
                    if (m_seen == {D{1'b1}}) begin
                        m_fv = 1;
                        m_seen = '0;
                    end
                end else begin
                    m_inv = 1;
                end
            end
            m_last_an = m_pend_an; m_last_ca = m_pend_ca; m_have_last = 1;
        end
        m_pend = 1; m_pend_an = a; m_pend_ca = c;
    endtask

    task automatic check_all();
        logic [4*D-1:0] ed;
        for (int i = 0; i < D; i++) ed[4*i +: 4] = m_dig[i];
        cmp("digits", 32'(digits), 32'(ed));
        cmp("digit_valid", 32'(digit_valid), 32'(m_dv));
        cmp("frame_valid", 32'(frame_valid), 32'(m_fv));
        cmp("invalid_pat", 32'(invalid_pat), 32'(m_inv));
        cmp("multi_an", 32'(multi_an), 32'(m_multi));
    endtask

    task automatic step(input logic [D-1:0] a, input logic [6:0] c);
        an = a; ca = c;
        @(posedge clk);
        model_edge(a, c);
        #1;
        check_all();
        fv_cnt  += int'(frame_valid);
        inv_cnt += int'(invalid_pat);
    endtask

    task automatic hold(input logic [D-1:0] a, input logic [6:0] c, input int n);
        for (int k = 0; k < n; k++) step(a, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("reset_digits", 32'(digits), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        glyphs[0]  = '{7'b0000001, 4'h0}; glyphs[1]  = '{7'b1001111, 4'h1};
        glyphs[2]  = '{7'b0010010, 4'h2}; glyphs[3]  = '{7'b0000110, 4'h3};
        glyphs[4]  = '{7'b1001100, 4'h4}; glyphs[5]  = '{7'b0100100, 4'h5};
        glyphs[6]  = '{7'b0100000, 4'h6}; glyphs[7]  = '{7'b0001111, 4'h7};
        glyphs[8]  = '{7'b0000000, 4'h8}; glyphs[9]  = '{7'b0000100, 4'h9};
        glyphs[10] = '{7'b0001000, 4'hA}; glyphs[11] = '{7'b1100000, 4'hB};
        glyphs[12] = '{7'b0110001, 4'hC}; glyphs[13] = '{7'b1000010, 4'hD};
        glyphs[14] = '{7'b0110000, 4'hE}; glyphs[15] = '{7'b0111000, 4'hF};
        model_reset();

        // Ordered sweep
        do_reset();
        hold(4'b1110, 7'b0000110, 6);
        hold(4'b1101, 7'b1001100, 6);
        hold(4'b1011, 7'b0001000, 6);
        for (int j = 0; j < 6; j++) begin
            step(4'b0111, 7'b0110001);
            cmp("sweep_fv_timing", 32'(frame_valid), (j == 4) ? 32'd1 : 32'd0);
        end
        cmp("sweep_digits", 32'(digits), 32'hCA43);
        cmp("sweep_dv", 32'(digit_valid), 32'hF);

        // Full glyph table on digit 0
        for (int g = 0; g < 16; g++) begin
            hold(4'b1110, glyphs[g].ca, 8);
            step(4'b1111, 7'b1111111);
            cmp("glyph_digit0", 32'(digits[3:0]), 32'(glyphs[g].hex));
        end

        // Glitch rejection, then a full-length run
        do_reset();
        hold(4'b1110, 7'b1001111, 3);
        hold(4'b1111, 7'b1111111, 3);
        cmp("glitch_dv", 32'(digit_valid), 32'h0);
        hold(4'b1110, 7'b1001111, 4);
        step(4'b1111, 7'b1111111);
        cmp("glitch_then_run", 32'(digits[3:0]), 32'h1);

        // Illegal pattern and multiple anodes
        inv_cnt = 0;
        hold(4'b1011, 7'b1111110, 5);
        hold(4'b1111, 7'b1111111, 2);
        cmp("illegal_inv_count", 32'(inv_cnt), 32'd1);
        cmp("illegal_dv2", 32'(digit_valid[2]), 32'd0);
        hold(4'b1100, 7'b0000110, 4);
        cmp("multi_an_held", 32'(multi_an), 32'd1);
        hold(4'b1111, 7'b1111111, 2);

        // Reset mid-frame discards the partial frame
        do_reset();
        hold(4'b1110, 7'b0000001, 6);
        hold(4'b1101, 7'b1001111, 6);
        do_reset();
        cmp("midframe_dv", 32'(digit_valid), 32'h0);
        fv_cnt = 0;
        hold(4'b1011, 7'b0010010, 6);
        hold(4'b0111, 7'b0000110, 6);
        cmp("midframe_no_fv", 32'(fv_cnt), 32'd0);
        cmp("midframe_dv2", 32'(digit_valid), 32'hC);

        // Long hold: one capture only
        do_reset();
        fv_cnt = 0;
        hold(4'b0111, 7'b0000000, 100);
        cmp("long_digit3", 32'(digits[15:12]), 32'h8);
        cmp("long_dv", 32'(digit_valid), 32'h8);
        cmp("long_fv_le1", 32'(fv_cnt <= 1), 32'd1);

        // Randomised traffic against the model
        for (int b = 0; b < 400; b++) begin
            logic [D-1:0] ra;
            logic [6:0]   rc;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = '1;
            else if (sel == 1) ra = D'($urandom) & D'($urandom);
            else               ra = ~(D'(1) << $urandom_range(0, D-1));
            if ($urandom_range(0, 7) == 0) rc = 7'($urandom);
            else                           rc = glyphs[$urandom_range(0, 15)].ca;
            hold(ra, rc, int'($urandom_range(1, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
